// File: rtl/vote_button_ctrl.sv
// vote_button_ctrl: synchronises and debounces four candidate buttons and issues one vote pulse per press.
// Optional VOTE_MULTI_PRESS_REJECT_EN: a simultaneous multi-button press is rejected and flagged on invalid_press.
module vote_btn_deb #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic deb
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      deb  <= 1'b0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], button};
      // any sample agreeing with the current level restarts the stability count
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module vote_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COOLDOWN_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic mode,
  input  logic button0,
  input  logic button1,
  input  logic button2,
  input  logic button3,
  output logic cand_valid_vote0,
  output logic cand_valid_vote1,
  output logic cand_valid_vote2,
  output logic cand_valid_vote3,
`ifdef VOTE_MULTI_PRESS_REJECT_EN
  output logic invalid_press,
`endif
  output logic busy
);
  localparam int NUM_BTN = 4;
  localparam int IW      = $clog2(NUM_BTN);
  localparam int CDW     = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [CDW-1:0] CD_LAST = CDW'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, VOTE, HOLD, COOLDOWN} state_t;

  logic [NUM_BTN-1:0] btn, deb, vote_q, vote_nxt;
  state_t             state, state_nxt;
  logic [CDW-1:0]     cd_cnt, cd_nxt;
  logic [IW-1:0]      idx_q, idx_nxt, sel;
  logic               any_deb;
`ifdef VOTE_MULTI_PRESS_REJECT_EN
  logic               multi, invalid_q;
`endif

  assign btn = {button3, button2, button1, button0};

  vote_btn_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [NUM_BTN-1:0] (
    .clock  (clock),
    .reset  (reset),
    .button (btn),
    .deb    (deb)
  );

  assign any_deb = |deb;

  always_comb begin
    state_nxt = state;
    cd_nxt    = cd_cnt;
    idx_nxt   = idx_q;
    vote_nxt  = '0;
    sel       = '0;
`ifdef VOTE_MULTI_PRESS_REJECT_EN
    multi     = 1'b0;
`endif
    // scan downward so the lowest asserted index wins
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (deb[i]) sel = IW'(i);
    end
    case (state)
      IDLE: begin
        if (!mode && any_deb) begin
          state_nxt = VOTE;
          idx_nxt   = sel;
`ifdef VOTE_MULTI_PRESS_REJECT_EN
          if ($countones(deb) > 1) begin
            state_nxt = HOLD;
            multi     = 1'b1;
          end
`endif
        end
      end
      VOTE: state_nxt = HOLD;
      HOLD: begin
        if (!any_deb) begin
          state_nxt = COOLDOWN;
          cd_nxt    = '0;
        end
      end
      COOLDOWN: begin
        if (any_deb) begin
          state_nxt = HOLD;
          cd_nxt    = '0;
        end else if (cd_cnt == CD_LAST) begin
          state_nxt = IDLE;
        end else begin
          cd_nxt = cd_cnt + CDW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == VOTE && !mode) vote_nxt[idx_nxt] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cd_cnt <= '0;
      idx_q  <= '0;
      vote_q <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cd_cnt <= cd_nxt;
      idx_q  <= idx_nxt;
      vote_q <= vote_nxt;
      busy   <= (state_nxt != IDLE);
    end
  end

`ifdef VOTE_MULTI_PRESS_REJECT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) invalid_q <= 1'b0;
    else        invalid_q <= multi;
  end
  assign invalid_press = invalid_q;
`endif

  assign cand_valid_vote0 = vote_q[0];
  assign cand_valid_vote1 = vote_q[1];
  assign cand_valid_vote2 = vote_q[2];
  assign cand_valid_vote3 = vote_q[3];
endmodule

// File: tb/tb_vote_button_ctrl.sv
// Scoreboard bench for vote_button_ctrl: a press-level reference model predicts pulses and busy.
module tb_vote_button_ctrl;
  localparam int D = 4;
  localparam int C = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic mode  = 1'b0;
  logic [3:0] btn = '0;
  logic v0, v1, v2, v3, busy;
`ifdef VOTE_MULTI_PRESS_REJECT_EN
  logic invp;
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  vote_button_ctrl #(.DEBOUNCE_CYCLES(D), .COOLDOWN_CYCLES(C)) dut (
    .clock            (clock),
    .reset            (reset),
    .mode             (mode),
    .button0          (btn[0]),
    .button1          (btn[1]),
    .button2          (btn[2]),
    .button3          (btn[3]),
    .cand_valid_vote0 (v0),
    .cand_valid_vote1 (v1),
    .cand_valid_vote2 (v2),
    .cand_valid_vote3 (v3),
`ifdef VOTE_MULTI_PRESS_REJECT_EN
    .invalid_press    (invp),
`endif
    .busy             (busy)
  );

  always #5 clock = ~clock;

  typedef struct {int cyc; int idx;} exp_t;
  exp_t vq[$];
  exp_t iq[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  // reference model: raw -> two sample delays -> level that changes after D disagreeing samples;
  // a press is "armed" only when idle; lockout ends after C quiet cycles with everything released
  int s1[4], s2[4], lvl[4], run[4];
  bit locked;       // a vote has been taken and the press is not finished yet
  bit quiet;        // all released, counting down the lockout
  bit vote_cyc;
  int quiet_left;
  bit mbusy;

  always @(posedge clock) begin
    int npress, low;
    cyc++;
    if (!reset) begin
      for (int b = 0; b < 4; b++) begin s1[b] = 0; s2[b] = 0; lvl[b] = 0; run[b] = 0; end
      locked = 0; quiet = 0; vote_cyc = 0; quiet_left = 0;
      mon_en = 1'b1;
    end else begin
      npress = 0; low = -1;
      for (int b = 3; b >= 0; b--) if (lvl[b] != 0) begin npress++; low = b; end
      if (!locked) begin
        if (mode == 1'b0 && npress > 0) begin
          locked = 1; quiet = 0;
          if (MULTI && npress > 1) begin
            iq.push_back('{cyc, 0});
          end else begin
            vq.push_back('{cyc, low});
            vote_cyc = 1;
          end
        end
      end else if (vote_cyc) begin
        vote_cyc = 0;
      end else if (!quiet) begin
        if (npress == 0) begin quiet = 1; quiet_left = C; end
      end else if (npress > 0) begin
        quiet = 0;
      end else begin
        quiet_left--;
        if (quiet_left == 0) begin locked = 0; quiet = 0; end
      end
      for (int b = 0; b < 4; b++) begin
        if (s2[b] == lvl[b]) run[b] = 0;
        else begin
          run[b]++;
          if (run[b] == D) begin lvl[b] = s2[b]; run[b] = 0; end
        end
        s2[b] = s1[b];
        s1[b] = int'(btn[b]);
      end
    end
    mbusy = reset ? locked : 1'b0;
  end

  // monitor: compares DUT outputs against the scoreboard away from the active edge
  always @(negedge clock) begin
    logic [3:0] v;
    exp_t e;
    if (mon_en) begin
      v = {v3, v2, v1, v0};
      total++;
      if (busy !== (reset ? mbusy : 1'b0)) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, (reset ? mbusy : 1'b0));
      end
      while (vq.size() > 0 && vq[0].cyc < cyc) begin
        e = vq.pop_front();
        total++; bad++;
        $display("FAIL missed_vote cyc=%0d got=none want=idx%0d@%0d", cyc, e.idx, e.cyc);
      end
      if (v !== 4'b0000) begin
        total++;
        if (vq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_vote cyc=%0d got=%b want=0000", cyc, v);
        end else begin
          e = vq.pop_front();
          if (e.cyc != cyc || v !== (4'b0001 << e.idx)) begin
            bad++;
            $display("FAIL vote cyc=%0d got=%b want=%b@%0d", cyc, v, 4'b0001 << e.idx, e.cyc);
          end
        end
      end
`ifdef VOTE_MULTI_PRESS_REJECT_EN
      while (iq.size() > 0 && iq[0].cyc < cyc) begin
        e = iq.pop_front();
        total++; bad++;
        $display("FAIL missed_invalid cyc=%0d got=0 want=1@%0d", cyc, e.cyc);
      end
      if (invp !== 1'b0) begin
        total++;
        if (iq.size() == 0 || iq[0].cyc != cyc) begin
          bad++;
          $display("FAIL invalid_press cyc=%0d got=%b want=0", cyc, invp);
        end else begin
          e = iq.pop_front();
        end
      end
`endif
    end
  end

  task automatic drive(input logic [3:0] b, input logic m, input int n);
    repeat (n) begin
      @(negedge clock); #1;
      btn = b; mode = m;
    end
  endtask

  task automatic noisy(input logic [3:0] mask, input logic m, input int n);
    repeat (n) begin
      @(negedge clock); #1;
      btn = mask & 4'($urandom_range(0, 15)); mode = m;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clock); #1;
    reset = 1'b0;
    noisy(4'hF, 1'b0, n);
    @(negedge clock); #1;
    btn = '0; reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] mask;
    // reset with buttons toggling
    reset = 1'b0;
    noisy(4'hF, 1'b0, 10);
    @(negedge clock); #1; btn = '0; reset = 1'b1;
    drive(4'h0, 1'b0, 12);
    // clean press on button2, then release and let cooldown expire
    drive(4'b0100, 1'b0, 40);
    drive(4'h0, 1'b0, 25);
    // bouncing button1 never settles, then a clean hold
    for (int i = 0; i < 10; i++) drive((i % 2) ? 4'b0000 : 4'b0010, 1'b0, 2);
    drive(4'h0, 1'b0, 20);
    drive(4'b0010, 1'b0, 10);
    drive(4'h0, 1'b0, 25);
    // result-display mode ignores a held button until mode returns to voting
    drive(4'b0001, 1'b1, 30);
    drive(4'b0001, 1'b0, 10);
    drive(4'h0, 1'b0, 25);
    // simultaneous press on buttons 1 and 3
    drive(4'b1010, 1'b0, 20);
    drive(4'h0, 1'b0, 25);
    // re-press three cycles into cooldown
    drive(4'b0001, 1'b0, 15);
    drive(4'h0, 1'b0, D + 2 + 1 + 3);
    drive(4'b0001, 1'b0, 15);
    drive(4'h0, 1'b0, 25);
    drive(4'b1000, 1'b0, 15);
    drive(4'h0, 1'b0, 25);
    // mode flipped to 1 mid-hold and mid-cooldown
    drive(4'b0100, 1'b0, 12);
    drive(4'b0100, 1'b1, 5);
    drive(4'h0, 1'b1, 10);
    drive(4'h0, 1'b0, 20);
    // reset asserted in the middle of a hold
    drive(4'b0010, 1'b0, 12);
    do_reset(4);
    drive(4'b0010, 1'b0, 12);
    drive(4'h0, 1'b0, 25);
    // randomized press segments with bounce
    for (int s = 0; s < 150; s++) begin
      case ($urandom_range(0, 5))
        0:       mask = 4'($urandom_range(0, 15));
        1:       mask = 4'h0;
        default: mask = 4'b0001 << $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 3) == 0) noisy(mask, 1'b0, $urandom_range(1, 6));
      drive(mask, ($urandom_range(0, 7) == 0), $urandom_range(1, 30));
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 4));
    end
    drive(4'h0, 1'b0, 40);
    total++;
    if (vq.size() != 0 || iq.size() != 0) begin
      bad++;
      $display("FAIL pending_expectations got=%0d want=0", vq.size() + iq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
